// File: rtl/m_if.sv
// Issue/result bundle between the execute stage and the RV32M multiply/divide unit.
// The execute stage is the master; m_unit is the slave.
interface m_if;
  logic        m_start;
  logic [2:0]  func3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rd;
  logic        pipeline_flush;
  logic [31:0] m_unit_result;
  logic        m_unit_ready;
  logic        m_unit_wr;
  logic [4:0]  m_unit_dest;
  logic        m_unit_busy;

  modport master (
    output m_start, func3, op1, op2, rd, pipeline_flush,
    input  m_unit_result, m_unit_ready, m_unit_wr, m_unit_dest, m_unit_busy
  );

  modport slave (
    input  m_start, func3, op1, op2, rd, pipeline_flush,
    output m_unit_result, m_unit_ready, m_unit_wr, m_unit_dest, m_unit_busy
  );
endinterface

// File: rtl/m_unit.sv
// RV32M multiply/divide unit: fixed-latency multiplier and 32-step restoring divider,
// returning a one-cycle result pulse and holding busy while an operation is in flight.
module m_unit #(
  parameter int MUL_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  m_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [4:0] MUL_LAST = (MUL_CYCLES > 1) ? 5'(MUL_CYCLES - 2) : 5'd0;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [2:0]  func3_q;
  logic [4:0]  rd_q;
  logic [31:0] a_q, b_q;
  logic [31:0] quo_q, rem_q, dvsr_q;
  logic        neg_quo_q, neg_rem_q;

  logic        accept, is_div, is_signed_div, div_zero, div_ovf, special;
  logic [32:0] rem_shift, rem_diff;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] div_out;

  assign accept        = (state == IDLE) && bus.m_start && !bus.pipeline_flush;
  assign is_div        = bus.func3[2];
  assign is_signed_div = !bus.func3[0];
  assign div_zero      = (bus.op2 == 32'd0);
  assign div_ovf       = is_signed_div && (bus.op1 == 32'h8000_0000) && (bus.op2 == 32'hFFFF_FFFF);
  assign special       = is_div && (div_zero || div_ovf);

  // One restoring step: shift the next dividend bit in, keep the difference if no borrow.
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};

  // MULH extends both operands signed, MULHSU only op1; the low word of MUL is sign-agnostic.
  assign a_ext = {{32{(func3_q == 3'd1 || func3_q == 3'd2) && a_q[31]}}, a_q};
  assign b_ext = {{32{(func3_q == 3'd1) && b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign div_out = func3_q[1] ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quo_q ? -quo_q : quo_q);

  always_ff @(posedge clk) begin
    // NOTE: all registered state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) begin
        if (!is_div)      state_nxt = (MUL_CYCLES == 1) ? DONE : MUL;
        else if (special) state_nxt = DONE;
        else              state_nxt = DIV;
      end
      MUL:  if (cnt == MUL_LAST) state_nxt = DONE;
      DIV:  if (cnt == 5'd31)    state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are individual flops, not a memory array, so they are reset
    // to keep X from ever reaching the result mux.
    if (rst) begin
      cnt       <= '0;
      func3_q   <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      func3_q <= bus.func3;
      rd_q    <= bus.rd;
      a_q     <= bus.op1;
      b_q     <= bus.op2;
      if (div_zero) begin
        quo_q     <= 32'hFFFF_FFFF;
        rem_q     <= bus.op1;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end else if (div_ovf) begin
        quo_q     <= 32'h8000_0000;
        rem_q     <= '0;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end else begin
        quo_q     <= (is_signed_div && bus.op1[31]) ? -bus.op1 : bus.op1;
        dvsr_q    <= (is_signed_div && bus.op2[31]) ? -bus.op2 : bus.op2;
        rem_q     <= '0;
        neg_quo_q <= is_signed_div && (bus.op1[31] ^ bus.op2[31]);
        neg_rem_q <= is_signed_div && bus.op1[31];
      end
    end else if (state == MUL) begin
      cnt <= cnt + 5'd1;
    end else if (state == DIV) begin
      cnt <= cnt + 5'd1;
      if (!rem_diff[32]) begin
        rem_q <= rem_diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= rem_shift[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    bus.m_unit_ready  = (state == DONE);
    bus.m_unit_busy   = (state != IDLE);
    bus.m_unit_result = '0;
    bus.m_unit_wr     = 1'b0;
    bus.m_unit_dest   = '0;
    if (state == DONE) begin
      bus.m_unit_result = func3_q[2] ? div_out
                        : (func3_q == 3'd0) ? prod[31:0] : prod[63:32];
      bus.m_unit_wr     = (rd_q != 5'd0);
      bus.m_unit_dest   = rd_q;
    end
  end

endmodule

// File: tb/tb_m_unit.sv
// Self-checking bench for m_unit: directed RV32M vectors, hazard sequences and
// randomized operations compared against a plain-arithmetic reference model.
module tb_m_unit;

  localparam int MUL_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  m_if bus();

  m_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext(input logic [31:0] v, input bit sgn);
    return sgn ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  // Reference result straight from the RV32M rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[31:0];  end
      3'd1: begin p = ext(a, 1'b1) * ext(b, 1'b1); return p[63:32]; end
      3'd2: begin p = ext(a, 1'b1) * ext(b, 1'b0); return p[63:32]; end
      3'd3: begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return sa / sb;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_CYCLES;
    if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    bus.func3   = f;
    bus.op1     = a;
    bus.op2     = b;
    bus.rd      = r;
    bus.m_start = 1'b1;
  endtask

  task automatic scramble();
    bus.m_start = 1'b0;
    bus.func3   = 3'($urandom);
    bus.op1     = $urandom;
    bus.op2     = $urandom;
    bus.rd      = 5'($urandom);
  endtask

  // Issues one op in an idle cycle and checks latency, busy profile and result fields.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
    int  n;
    bit  got;
    @(negedge clk);
    check({tag, ":idle_ready"}, 32'(bus.m_unit_ready), 32'd0);
    check({tag, ":accept_busy"}, 32'(bus.m_unit_busy), 32'd0);
    drive(f, a, b, r);
    @(posedge clk);
    #1 scramble();
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.m_unit_ready) got = 1;
      else check({tag, ":busy"}, 32'(bus.m_unit_busy), 32'd1);
    end
    check({tag, ":latency"}, 32'(n), 32'(ref_latency(f, a, b)));
    if (got) begin
      check({tag, ":result"}, bus.m_unit_result, exp);
      check({tag, ":wr"}, 32'(bus.m_unit_wr), 32'(r != 0));
      check({tag, ":dest"}, 32'(bus.m_unit_dest), 32'(r));
      check({tag, ":busy_ready"}, 32'(bus.m_unit_busy), 32'd1);
    end
  endtask

  initial begin
    int pulses, ready_at, bad;
    logic [31:0] captured;
    logic [2:0]  f;
    logic [31:0] a, b;

    rst = 1'b1;
    bus.pipeline_flush = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst:ready", 32'(bus.m_unit_ready), 32'd0);
    check("rst:busy", 32'(bus.m_unit_busy), 32'd0);
    check("rst:result", bus.m_unit_result, 32'd0);
    check("rst:wr", 32'(bus.m_unit_wr), 32'd0);
    check("rst:dest", 32'(bus.m_unit_dest), 32'd0);

    // Directed vectors; consecutive calls also exercise back-to-back issue after ready.
    run_op("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op("mulhu",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE);
    run_op("mulh",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'd0);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF);
    run_op("div",      3'd4, -32'sd20,       32'd3,         5'd9,  32'hFFFF_FFFA);
    run_op("rem",      3'd6, -32'sd20,       32'd3,         5'd10, 32'hFFFF_FFFE);
    run_op("divu",     3'd5, 32'd100,        32'd7,         5'd11, 32'd14);
    run_op("remu",     3'd7, 32'd100,        32'd7,         5'd12, 32'd2);
    run_op("divu_z",   3'd5, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF);
    run_op("rem_z",    3'd6, 32'd5,          32'd0,         5'd14, 32'd5);
    run_op("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    run_op("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0);
    run_op("mul_rd0",  3'd0, 32'd3,          32'd4,         5'd0,  32'd12);

    // m_start during a divide is ignored: exactly one ready, at T+33.
    @(negedge clk);
    drive(3'd5, 32'd1000, 32'd9, 5'd20);
    @(posedge clk);
    #1 scramble();
    pulses = 0; ready_at = 0; captured = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.m_unit_ready) begin
        pulses++;
        ready_at = n;
        captured = bus.m_unit_result;
      end
      if (n == 10) drive(3'd0, 32'd2, 32'd3, 5'd21);
      if (n == 11) bus.m_start = 1'b0;
    end
    check("busy_start:pulses", 32'(pulses), 32'd1);
    check("busy_start:ready_at", 32'(ready_at), 32'd33);
    check("busy_start:result", captured, 32'd111);

    // Reset mid-divide abandons the op.
    @(negedge clk);
    drive(3'd4, 32'd12345, 32'd17, 5'd3);
    @(posedge clk);
    #1 scramble();
    bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n >= 11 && (bus.m_unit_busy || bus.m_unit_ready)) bad++;
      if (n == 10) rst = 1'b1;
      if (n == 11) rst = 1'b0;
    end
    check("mid_rst:quiet_cycles", 32'(bad), 32'd0);

    // Flush in the issue cycle blocks the accept.
    @(negedge clk);
    drive(3'd5, 32'd50, 32'd5, 5'd4);
    bus.pipeline_flush = 1'b1;
    @(posedge clk);
    #1 scramble();
    bus.pipeline_flush = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.m_unit_busy || bus.m_unit_ready) bad++;
    end
    check("flush:no_accept", 32'(bad), 32'd0);

    // m_start in the DONE cycle is dropped.
    @(negedge clk);
    drive(3'd0, 32'd6, 32'd7, 5'd1);
    @(posedge clk);
    #1 scramble();
    bad = 0;
    while (!bus.m_unit_ready && bad < 10) begin
      @(negedge clk);
      bad++;
    end
    check("done_start:ready_seen", 32'(bus.m_unit_ready), 32'd1);
    drive(3'd5, 32'd9, 32'd3, 5'd2);
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    check("done_start:busy", 32'(bus.m_unit_busy), 32'd0);
    check("done_start:ready", 32'(bus.m_unit_ready), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = $urandom_range(0, 255);
        2: a = 32'h8000_0000;
        default: a = 32'hFFFF_FFFF;
      endcase
      case ($urandom_range(0, 4))
        0, 1: b = $urandom;
        2: b = $urandom_range(0, 15);
        3: b = 32'hFFFF_FFFF;
        default: b = 32'd0;
      endcase
      run_op($sformatf("rand%0d", i), f, a, b, 5'($urandom), ref_result(f, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
